// File: rtl/uart_prog_loader.sv
// uart_prog_loader: receive-side UART program loader. Deserialises an 8N1 frame
// stream and packs the bytes little-endian into 32-bit words. Each word is
// written to instruction memory at incrementing word addresses until the EOF
// word arrives or memory is full.
// Optional feature macro: UART_PARITY_EN (8E1 frames with a parity check).
module uart_prog_loader #(
    parameter int          CLKS_PER_BIT = 347,
    parameter int          ADDR_W       = 10,
    parameter logic [31:0] EOF_WORD     = 32'h00000FFF
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              en_i,
    input  logic              rx_i,
    output logic              ready_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    output logic              done_o,
    output logic              frame_err_o,
    output logic              parity_err_o
);
    localparam int                CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]  FULL_TICK = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  HALF_TICK = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [ADDR_W-1:0] ADDR_MAX  = {ADDR_W{1'b1}};

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_PARITY_EN
        ST_PARITY = 3'd4,
`endif
        ST_STOP   = 3'd3
    } state_t;

`ifdef UART_PARITY_EN
    // Even parity bit for a data byte (bit value that makes the total count of ones even).
    function automatic logic even_parity(input logic [7:0] d);
        return ^d;
    endfunction
`endif

    logic              rx_meta_r, rx_sync_r;
    state_t            state_r, state_s;
    logic [CNT_W-1:0]  clk_cnt_r;
    logic [2:0]        bit_cnt_r;
    logic [7:0]        shift_r;
    logic              half_tick_s, full_tick_s;
    logic              cnt_clr_s, bit_clr_s, shift_en_s, stop_smp_s, par_chk_s;
    logic              par_ok_s, byte_valid_s, frame_err_set_s;
    logic [1:0]        byte_idx_r;
    logic [31:0]       word_r, word_full_s, wdata_r;
    logic [ADDR_W-1:0] addr_r;
    logic              we_r, done_r, frame_err_r, ready_r;

    assign half_tick_s = (clk_cnt_r == HALF_TICK);
    assign full_tick_s = (clk_cnt_r == FULL_TICK);

    // Two-flop synchroniser for the asynchronous serial input (idles high).
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
        end else begin
            rx_meta_r <= rx_i;
            rx_sync_r <= rx_meta_r;
        end
    end

    // RX FSM state register; disabling the loader parks it in IDLE.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i)   state_r <= ST_IDLE;
        else if (!en_i) state_r <= ST_IDLE;
        else            state_r <= state_s;
    end

    // RX FSM next-state logic: mid-bit sampling, start-bit glitch reject, no full stop-bit wait.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE:  if (!rx_sync_r) state_s = ST_START; else state_s = ST_IDLE;
            ST_START: begin
                if (half_tick_s) state_s = rx_sync_r ? ST_IDLE : ST_DATA;
                else             state_s = ST_START;
            end
            ST_DATA: begin
`ifdef UART_PARITY_EN
                if (full_tick_s && (bit_cnt_r == 3'd7)) state_s = ST_PARITY;
`else
                if (full_tick_s && (bit_cnt_r == 3'd7)) state_s = ST_STOP;
`endif
                else                                    state_s = ST_DATA;
            end
`ifdef UART_PARITY_EN
            ST_PARITY: if (full_tick_s) state_s = ST_STOP; else state_s = ST_PARITY;
`endif
            ST_STOP:  if (full_tick_s) state_s = ST_IDLE; else state_s = ST_STOP;
            default:  state_s = ST_IDLE;
        endcase
    end

    // RX FSM outputs: counter control and per-state sample strobes.
    always_comb begin
        cnt_clr_s  = 1'b0;
        bit_clr_s  = 1'b0;
        shift_en_s = 1'b0;
        stop_smp_s = 1'b0;
        par_chk_s  = 1'b0;
        case (state_r)
            ST_IDLE:   begin cnt_clr_s = 1'b1; bit_clr_s = 1'b1; end
            ST_START:  cnt_clr_s = half_tick_s;
            ST_DATA:   begin cnt_clr_s = full_tick_s; shift_en_s = full_tick_s; end
`ifdef UART_PARITY_EN
            ST_PARITY: begin cnt_clr_s = full_tick_s; par_chk_s = full_tick_s; end
`endif
            ST_STOP:   begin cnt_clr_s = full_tick_s; stop_smp_s = full_tick_s; end
            default:   begin cnt_clr_s = 1'b1; bit_clr_s = 1'b1; end
        endcase
    end

`ifdef UART_PARITY_EN
    logic par_bad_r, parity_err_r;

    // Parity tracking: remember a mismatch for the current frame, sticky error flag.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            par_bad_r    <= 1'b0;
            parity_err_r <= 1'b0;
        end else if (!en_i) begin
            par_bad_r    <= 1'b0;
            parity_err_r <= 1'b0;
        end else if (bit_clr_s) begin
            par_bad_r    <= 1'b0;
        end else if (par_chk_s && (rx_sync_r != even_parity(shift_r))) begin
            par_bad_r    <= 1'b1;
            parity_err_r <= 1'b1;
        end
    end

    assign par_ok_s     = ~par_bad_r;
    assign parity_err_o = parity_err_r;
`else
    assign par_ok_s     = 1'b1;
    assign parity_err_o = 1'b0;
`endif

    assign byte_valid_s    = stop_smp_s & rx_sync_r & par_ok_s;
    assign frame_err_set_s = stop_smp_s & ~rx_sync_r;
    assign word_full_s     = {shift_r, word_r[23:0]};

    // Bit-timing counter, data bit counter and LSB-first shift register.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            clk_cnt_r <= '0;
            bit_cnt_r <= 3'd0;
            shift_r   <= 8'h00;
        end else if (!en_i) begin
            clk_cnt_r <= '0;
            bit_cnt_r <= 3'd0;
            shift_r   <= 8'h00;
        end else begin
            clk_cnt_r <= cnt_clr_s ? '0 : clk_cnt_r + CNT_W'(1);
            if (bit_clr_s)       bit_cnt_r <= 3'd0;
            else if (shift_en_s) bit_cnt_r <= bit_cnt_r + 3'd1;
            if (shift_en_s)      shift_r   <= {rx_sync_r, shift_r[7:1]};
        end
    end

    // Word assembler and memory write port; done freezes loading until cleared.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            byte_idx_r  <= 2'd0;
            word_r      <= 32'h0;
            wdata_r     <= 32'h0;
            addr_r      <= '0;
            we_r        <= 1'b0;
            done_r      <= 1'b0;
            frame_err_r <= 1'b0;
            ready_r     <= 1'b0;
        end else if (!en_i) begin
            byte_idx_r  <= 2'd0;
            word_r      <= 32'h0;
            wdata_r     <= 32'h0;
            addr_r      <= '0;
            we_r        <= 1'b0;
            done_r      <= 1'b0;
            frame_err_r <= 1'b0;
            ready_r     <= 1'b0;
        end else begin
            ready_r <= ~done_r;
            we_r    <= 1'b0;
            if (we_r && (addr_r != ADDR_MAX)) addr_r <= addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
            if (frame_err_set_s) frame_err_r <= 1'b1;
            if (byte_valid_s && !done_r) begin
                if (byte_idx_r == 2'd3) begin
                    byte_idx_r <= 2'd0;
                    if (word_full_s == EOF_WORD) begin
                        done_r <= 1'b1;
                    end else begin
                        we_r    <= 1'b1;
                        wdata_r <= word_full_s;
                        if (addr_r == ADDR_MAX) done_r <= 1'b1;
                    end
                end else begin
                    word_r[{byte_idx_r, 3'b000} +: 8] <= shift_r;
                    byte_idx_r <= byte_idx_r + 2'd1;
                end
            end
        end
    end

    assign ready_o     = ready_r;
    assign mem_we_o    = we_r;
    assign mem_addr_o  = addr_r;
    assign mem_wdata_o = wdata_r;
    assign done_o      = done_r;
    assign frame_err_o = frame_err_r;
endmodule

// File: tb/tb_uart_prog_loader.sv
// Directed bench for uart_prog_loader with a short bit time and a 4-word memory.
module tb_uart_prog_loader;
    localparam int CPB = 16;
    localparam int AW  = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en  = 1'b0;
    logic          rx  = 1'b1;
    logic          ready, we, done, ferr, perr;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;

    int            tests = 0;
    int            fails = 0;
    int            wr_cnt = 0;
    int            base;
    logic [31:0]   wr_addr_q[$];
    logic [31:0]   wr_data_q[$];

    uart_prog_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(AW), .EOF_WORD(32'h00000FFF)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .en_i(en), .rx_i(rx),
        .ready_o(ready), .mem_we_o(we), .mem_addr_o(addr), .mem_wdata_o(wdata),
        .done_o(done), .frame_err_o(ferr), .parity_err_o(perr)
    );

    always #5 clk = ~clk;

    // Record every cycle the write strobe is high.
    always @(negedge clk) begin
        if (we) begin
            wr_addr_q.push_back(32'(addr));
            wr_data_q.push_back(wdata);
            wr_cnt = wr_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests = tests + 1;
        assert (obs === exp) else begin
            fails = fails + 1;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_b);
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            tick(CPB);
        end
`ifdef UART_PARITY_EN
        rx = par_b;
        tick(CPB);
`else
        if (par_b === 1'bx) tick(1);
`endif
        rx = stop_b;
        tick(CPB);
        rx = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] d);
        send_frame(d, 1'b1, ^d);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
        tick(4);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(3);
    endtask

    initial begin
        tick(3);
        // Reset state
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_we",    32'(we),    32'd0);
        check("rst_done",  32'(done),  32'd0);
        check("rst_ferr",  32'(ferr),  32'd0);
        check("rst_addr",  32'(addr),  32'd0);
        check("rst_wdata", wdata,      32'd0);
        rst = 1'b0;
        tick(2);
        en = 1'b1;
        @(negedge clk);
        check("ready_lat0", 32'(ready), 32'd0);
        @(negedge clk);
        check("ready_lat1", 32'(ready), 32'd1);
        tick(2);

        // 1: single word 13 05 00 00
        base = wr_cnt;
        send_byte(8'h13); send_byte(8'h05); send_byte(8'h00); send_byte(8'h00);
        tick(4);
        check("t1_nwr",  32'(wr_cnt - base), 32'd1);
        check("t1_addr", wr_addr_q[base],    32'd0);
        check("t1_data", wr_data_q[base],    32'h00000513);
        check("t1_next", 32'(addr),          32'd1);

        // 2: three words then EOF, then more bytes ignored
        do_reset();
        base = wr_cnt;
        send_word(32'h11111111); send_word(32'h22222222); send_word(32'h33333333);
        check("t2_nwr",   32'(wr_cnt - base),  32'd3);
        check("t2_a0",    wr_addr_q[base],     32'd0);
        check("t2_a2",    wr_addr_q[base + 2], 32'd2);
        check("t2_d1",    wr_data_q[base + 1], 32'h22222222);
        check("t2_done0", 32'(done),           32'd0);
        send_word(32'h00000FFF);
        tick(2);
        check("t2_eof_nwr", 32'(wr_cnt - base), 32'd3);
        check("t2_done",    32'(done),          32'd1);
        check("t2_ready",   32'(ready),         32'd0);
        send_word(32'h44444444);
        check("t2_after_nwr", 32'(wr_cnt - base), 32'd3);
        check("t2_after_addr", 32'(addr),         32'd3);

        // 3: stop bit low -> frame error, following word intact
        do_reset();
        base = wr_cnt;
        send_frame(8'h5A, 1'b0, 1'b0);
        tick(2 * CPB);
        check("t3_ferr", 32'(ferr),          32'd1);
        check("t3_nwr0", 32'(wr_cnt - base), 32'd0);
        send_word(32'hCAFEF00D);
        check("t3_nwr",  32'(wr_cnt - base), 32'd1);
        check("t3_addr", wr_addr_q[base],    32'd0);
        check("t3_data", wr_data_q[base],    32'hCAFEF00D);
        check("t3_ferr_sticky", 32'(ferr),   32'd1);

        // 4: short low glitch is rejected
        do_reset();
        base = wr_cnt;
        rx = 1'b0;
        tick(CPB / 4);
        rx = 1'b1;
        tick(3 * CPB);
        check("t4_ferr", 32'(ferr),          32'd0);
        check("t4_nwr0", 32'(wr_cnt - base), 32'd0);
        send_word(32'hDEADBEEF);
        check("t4_nwr",  32'(wr_cnt - base), 32'd1);
        check("t4_data", wr_data_q[base],    32'hDEADBEEF);

        // 5: drop enable mid-word, then fill the 4-word memory
        do_reset();
        base = wr_cnt;
        send_byte(8'hAA); send_byte(8'hBB);
        en = 1'b0;
        tick(2);
        check("t5_ready_off", 32'(ready), 32'd0);
        en = 1'b1;
        tick(2);
        send_word(32'h04030201);
        check("t5_nwr",  32'(wr_cnt - base), 32'd1);
        check("t5_addr", wr_addr_q[base],    32'd0);
        check("t5_data", wr_data_q[base],    32'h04030201);
        send_word(32'h0000AAAA); send_word(32'h0000BBBB);
        check("t5_done_pre", 32'(done), 32'd0);
        send_word(32'h0000CCCC);
        check("t5_full_nwr",  32'(wr_cnt - base), 32'd4);
        check("t5_full_a3",   wr_addr_q[base + 3], 32'd3);
        check("t5_full_d3",   wr_data_q[base + 3], 32'h0000CCCC);
        check("t5_full_done", 32'(done),           32'd1);
        send_word(32'h0000DDDD);
        check("t5_nowrap_nwr",  32'(wr_cnt - base), 32'd4);
        check("t5_nowrap_addr", 32'(addr),          32'd3);

`ifdef UART_PARITY_EN
        // 6: bad parity drops the byte, good parity accepts it
        do_reset();
        base = wr_cnt;
        send_frame(8'hA5, 1'b1, 1'b1);
        tick(4);
        check("t6_perr", 32'(perr), 32'd1);
        send_frame(8'hA5, 1'b1, 1'b0);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
        tick(4);
        check("t6_nwr",  32'(wr_cnt - base), 32'd1);
        check("t6_data", wr_data_q[base],    32'h030201A5);
`else
        check("perr_tied", 32'(perr), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
